// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: BCD stopwatch with prescaled tick, pause/resume, sticky overflow and
// optional lap capture (enabled by defining BCD_STOPWATCH_LAP_EN).
module bcd_stopwatch #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_stop,
    input  logic                clear,
    input  logic                lap,
    output logic [4*DIGITS-1:0] count,
    output logic [4*DIGITS-1:0] lap_value,
    output logic                lap_valid,
    output logic                running,
    output logic                overflow
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    state_t              state;
    logic [15:0]         presc;
    logic                tick;
    logic                carry;
    logic [3:0]          digit;
    logic [4*DIGITS-1:0] count_inc;

    assign tick = state == RUN && presc == 16'(PRESCALE - 1);

    // Ripple a +1 through the digits; carry ends high only when every digit was 9.
    always_comb begin
        carry     = 1'b1;
        digit     = '0;
        count_inc = count;
        for (int i = 0; i < DIGITS; i++) begin
            digit                = count[4*i +: 4];
            count_inc[4*i +: 4]  = carry ? (digit == 4'd9 ? 4'd0 : digit + 4'd1) : digit;
            carry                = carry && digit == 4'd9;
        end
    end

    // State machine, prescaler, count and sticky overflow; clear acts like reset here.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state    <= IDLE;
            presc    <= '0;
            count    <= '0;
            running  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (start_stop)
                state <= state == RUN ? PAUSE : RUN;
            running <= start_stop ? state != RUN : state == RUN;
            presc   <= tick ? '0 : state == RUN ? presc + 16'd1 : state == PAUSE ? presc : '0;
            if (tick)
                count <= count_inc;
            if (tick && carry)
                overflow <= 1'b1;
        end
    end

`ifdef BCD_STOPWATCH_LAP_EN
    // Lap capture takes the pre-edge count, so a tick-cycle lap sees the old value.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lap_value <= '0;
            lap_valid <= 1'b0;
        end else begin
            lap_valid <= lap;
            if (lap)
                lap_value <= count;
        end
    end
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign lap_value  = '0;
    assign lap_valid  = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch: three stopwatch configurations driven in lockstep against an
// integer-counting reference model, plus directed corner-case checks.
module tb_bcd_stopwatch;
    localparam int DG[3] = '{4, 2, 4};
    localparam int PS[3] = '{10, 1, 4};

    logic clk, reset, start_stop, clear, lap;
    logic [15:0] c0, l0, c2, l2;
    logic [7:0]  c1, l1;
    logic [2:0]  val, run, ov;
    logic [31:0] a_cnt[3], a_lv[3];

    bcd_stopwatch #(.DIGITS(4), .PRESCALE(10)) dut0 (.clk(clk), .reset(reset), .start_stop(start_stop),
        .clear(clear), .lap(lap), .count(c0), .lap_value(l0), .lap_valid(val[0]), .running(run[0]), .overflow(ov[0]));
    bcd_stopwatch #(.DIGITS(2), .PRESCALE(1)) dut1 (.clk(clk), .reset(reset), .start_stop(start_stop),
        .clear(clear), .lap(lap), .count(c1), .lap_value(l1), .lap_valid(val[1]), .running(run[1]), .overflow(ov[1]));
    bcd_stopwatch #(.DIGITS(4), .PRESCALE(4)) dut2 (.clk(clk), .reset(reset), .start_stop(start_stop),
        .clear(clear), .lap(lap), .count(c2), .lap_value(l2), .lap_valid(val[2]), .running(run[2]), .overflow(ov[2]));

    assign a_cnt[0] = {16'b0, c0};
    assign a_cnt[1] = {24'b0, c1};
    assign a_cnt[2] = {16'b0, c2};
    assign a_lv[0]  = {16'b0, l0};
    assign a_lv[1]  = {24'b0, l1};
    assign a_lv[2]  = {16'b0, l2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          k;
        logic [31:0] cnt;
        logic [31:0] lv;
        logic        val;
        logic        run;
        logic        ov;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic r, s, c, l;
        int   reps;
        logic exp_run;
    } vec_t;

    int m_st[3], m_pr[3], m_n[3], m_lv[3];
    bit m_val[3], m_ov[3];
    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] bcd(input int v, input int d);
        logic [31:0] r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: count held as an integer, state 0=idle 1=run 2=pause.
    task automatic model_step(input int k, input logic r, s, c, l);
        int lim = 1;
        bit tk;
        for (int i = 0; i < DG[k]; i++) lim *= 10;
        if (r || c) begin
            m_st[k] = 0; m_pr[k] = 0; m_n[k] = 0; m_lv[k] = 0; m_val[k] = 0; m_ov[k] = 0;
        end else begin
            tk = m_st[k] == 1 && m_pr[k] == PS[k] - 1;
`ifdef BCD_STOPWATCH_LAP_EN
            m_val[k] = l;
            if (l) m_lv[k] = m_n[k];
`endif
            if (tk) begin
                m_pr[k] = 0;
                m_n[k]++;
                if (m_n[k] == lim) begin
                    m_n[k] = 0;
                    m_ov[k] = 1;
                end
            end else if (m_st[k] == 1) m_pr[k]++;
            else if (m_st[k] == 0) m_pr[k] = 0;
            if (s) m_st[k] = m_st[k] == 1 ? 2 : 1;
        end
    endtask

    task automatic cyc(input logic r, s, c, l);
        exp_t e;
        reset = r; start_stop = s; clear = c; lap = l;
        for (int k = 0; k < 3; k++) begin
            model_step(k, r, s, c, l);
            e.k = k; e.cnt = bcd(m_n[k], DG[k]); e.lv = bcd(m_lv[k], DG[k]);
            e.val = m_val[k]; e.run = m_st[k] == 1; e.ov = m_ov[k];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("count%0d", e.k), a_cnt[e.k], e.cnt);
            chk($sformatf("lap_value%0d", e.k), a_lv[e.k], e.lv);
            chk($sformatf("lap_valid%0d", e.k), 32'(val[e.k]), 32'(e.val));
            chk($sformatf("running%0d", e.k), 32'(run[e.k]), 32'(e.run));
            chk($sformatf("overflow%0d", e.k), 32'(ov[e.k]), 32'(e.ov));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    vec_t tbl[13];
    logic exp_lv;

    initial begin
        reset = 1; start_stop = 0; clear = 0; lap = 0;
        tbl[0]  = '{1, 0, 0, 0, 1, 0};
        tbl[1]  = '{0, 1, 0, 0, 1, 1};
        tbl[2]  = '{0, 0, 0, 0, 7, 1};
        tbl[3]  = '{0, 1, 0, 0, 1, 0};
        tbl[4]  = '{0, 1, 0, 0, 3, 1};
        tbl[5]  = '{0, 0, 0, 1, 2, 1};
        tbl[6]  = '{0, 0, 1, 0, 1, 0};
        tbl[7]  = '{0, 0, 0, 1, 1, 0};
        tbl[8]  = '{0, 1, 0, 0, 1, 1};
        tbl[9]  = '{0, 0, 0, 0, 13, 1};
        tbl[10] = '{0, 1, 1, 0, 1, 0};
        tbl[11] = '{0, 1, 0, 1, 1, 1};
        tbl[12] = '{1, 1, 0, 1, 1, 0};
        for (int k = 0; k < 3; k++) model_step(k, 1, 0, 0, 0);

        cyc(1, 0, 0, 0);
        chk("reset_count", a_cnt[0], 0);
        chk("reset_running", 32'(run[0]), 0);
        chk("reset_overflow", 32'(ov[0]), 0);

        for (int v = 0; v < 13; v++) begin
            for (int j = 0; j < tbl[v].reps; j++) cyc(tbl[v].r, tbl[v].s, tbl[v].c, tbl[v].l);
            chk($sformatf("vec%0d_running", v), 32'(run[0]), 32'(tbl[v].exp_run));
        end

        // 100 cycles at prescale 10 after a start pulse.
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); idle(100);
        chk("run100_count", a_cnt[0], 32'h0010);
        chk("run100_running", 32'(run[0]), 1);

        // Two-digit wrap to zero with sticky overflow.
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); idle(99);
        chk("preload_99", a_cnt[1], 32'h99);
        chk("preload_ov", 32'(ov[1]), 0);
        idle(1);
        chk("wrap_count", a_cnt[1], 32'h00);
        chk("wrap_ov", 32'(ov[1]), 1);
        idle(3);
        chk("ov_sticky", 32'(ov[1]), 1);
        cyc(0, 0, 1, 0);
        chk("clear_ov", 32'(ov[1]), 0);

        // Pause mid-prescale then resume: next increment exactly two cycles later.
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); idle(1); cyc(0, 1, 0, 0);
        idle(20);
        chk("pause_frozen", a_cnt[2], 0);
        cyc(0, 1, 0, 0); idle(1);
        chk("resume_plus1", a_cnt[2], 0);
        idle(1);
        chk("resume_plus2", a_cnt[2], 1);

        // Tick and start_stop in the same run cycle.
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); idle(1); cyc(0, 1, 0, 0);
        chk("tick_pause_count", a_cnt[1], 2);
        chk("tick_pause_running", 32'(run[1]), 0);

        // Lap on a tick cycle captures the pre-increment count.
`ifdef BCD_STOPWATCH_LAP_EN
        exp_lv = 1;
`else
        exp_lv = 0;
`endif
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); idle(9);
        chk("pre_lap_count", a_cnt[1], 32'h09);
        cyc(0, 0, 0, 1);
        chk("lap_count", a_cnt[1], 32'h10);
        chk("lap_value", a_lv[1], exp_lv ? 32'h09 : 32'h0);
        chk("lap_valid", 32'(val[1]), 32'(exp_lv));
        idle(1);
        chk("lap_valid_drop", 32'(val[1]), 0);
        chk("lap_hold", a_lv[1], exp_lv ? 32'h09 : 32'h0);

        // Clear dominates start_stop and lap in run.
        cyc(0, 1, 1, 1);
        chk("clr_all_count", a_cnt[0], 0);
        chk("clr_all_running", 32'(run[0]), 0);
        chk("clr_all_valid", 32'(val[0]), 0);

        // Reset mid-count at 0x0123 dominates everything.
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); idle(123 * 4);
        chk("count_0123", a_cnt[2], 32'h0123);
        cyc(1, 1, 1, 1);
        chk("rst_count", a_cnt[2], 0);
        chk("rst_lap_value", a_lv[2], 0);
        chk("rst_valid", 32'(val[2]), 0);
        chk("rst_running", 32'(run[2]), 0);
        chk("rst_ov", 32'(ov[2]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
